// File: rtl/calc_pkg.sv
// Shared calculator definitions: opcodes, ASCII constants, formatter states and
// the leading-digit helper used by the result formatter.
package calc_pkg;

    localparam int CALC_RES_W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_SIGN,
        ST_DIGIT,
        ST_ERR,
        ST_TAIL
    } fmt_state_t;

    // Index of the most significant printed digit (2 = hundreds), so leading
    // zeros are skipped without spending cycles on them.
    function automatic logic [1:0] first_digit(input logic [CALC_RES_W-1:0] v);
        if (v >= CALC_RES_W'(100))
            return 2'd2;
        else if (v >= CALC_RES_W'(10))
            return 2'd1;
        else
            return 2'd0;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, DATA_W cycles
// after the start pulse, producing three BCD digits.
module bin2bcd_seq #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic [2:0][3:0]   bcd,
    output logic              done
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shreg;
    logic [11:0]       acc;
    logic [CW-1:0]     cnt;
    logic [10:0]       adj;

    function automatic logic [3:0] fix(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // The hundreds digit stays below 5 for inputs of at most 8 bits, so only
    // the lower two digits ever need the +3 correction.
    assign adj  = {acc[10:8], fix(acc[7:4]), fix(acc[3:0])};
    assign bcd  = acc;
    assign done = (cnt == CW'(1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (start) begin
            shreg <= value;
            acc   <= '0;
            cnt   <= CW'(DATA_W);
        end else if (cnt != '0) begin
            shreg <= shreg << 1;
            acc   <= {adj, shreg[DATA_W-1]};
            cnt   <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/calc_result_formatter.sv
// Turns one calculator record into an ASCII character stream on valid/ready.
// Define CALC_FMT_NEWLINE_EN to append a line feed to every record.
module calc_result_formatter
    import calc_pkg::*;
#(
    parameter int DATA_W = CALC_RES_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] result,
    input  logic              neg,
    input  logic              div_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic              out_last
);

`ifdef CALC_FMT_NEWLINE_EN
    localparam fmt_state_t END_ST    = ST_TAIL;
    localparam logic       LAST_BODY = 1'b0;
`else
    localparam fmt_state_t END_ST    = ST_IDLE;
    localparam logic       LAST_BODY = 1'b1;
`endif

    fmt_state_t     state, state_n;
    logic           neg_q, nz_q;
    logic [1:0]     pos;
    logic           pos_dec;
    logic           accept;
    logic           conv_done;
    logic [2:0][3:0] bcd;
    logic [3:0]     digit;

    bin2bcd_seq #(.DATA_W(DATA_W)) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && !div_zero),
        .value (result),
        .bcd   (bcd),
        .done  (conv_done)
    );

    // pos walks down to 0: digit index in DIGIT, character index in ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            neg_q <= 1'b0;
            nz_q  <= 1'b0;
            pos   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                neg_q <= neg;
                nz_q  <= |result;
                pos   <= div_zero ? 2'd2 : first_digit(CALC_RES_W'(result));
            end else if (pos_dec) begin
                pos <= pos - 2'd1;
            end
        end
    end

    always_comb begin
        case (pos)
            2'd2:    digit = bcd[2];
            2'd1:    digit = bcd[1];
            default: digit = bcd[0];
        endcase
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_char  = 8'h00;
        out_last  = 1'b0;
        pos_dec   = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_n = div_zero ? ST_ERR : ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done)
                    state_n = (neg_q && nz_q) ? ST_SIGN : ST_DIGIT;
            end
            ST_SIGN: begin
                out_valid = 1'b1;
                out_char  = CH_MINUS;
                if (out_ready)
                    state_n = ST_DIGIT;
            end
            ST_DIGIT, ST_ERR: begin
                out_valid = 1'b1;
                out_last  = LAST_BODY && (pos == 2'd0);
                if (state == ST_ERR)
                    out_char = (pos == 2'd2) ? CH_E : CH_R;
                else
                    out_char = CH_ZERO | {4'h0, digit};
                if (out_ready) begin
                    if (pos == 2'd0)
                        state_n = END_ST;
                    else
                        pos_dec = 1'b1;
                end
            end
`ifdef CALC_FMT_NEWLINE_EN
            ST_TAIL: begin
                out_valid = 1'b1;
                out_char  = CH_LF;
                out_last  = 1'b1;
                if (out_ready)
                    state_n = ST_IDLE;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_calc_result_formatter.sv
// Randomized self-checking bench for calc_result_formatter against a decimal
// string model; honours CALC_FMT_NEWLINE_EN the same way the design does.
module tb_calc_result_formatter;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] result = '0;
    logic              neg = 1'b0;
    logic              div_zero = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [7:0]        out_char;
    logic              out_last;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    calc_result_formatter #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .neg       (neg),
        .div_zero  (div_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected text of a record, built from its decimal value.
    function automatic void build_exp(input int r, input bit n, input bit dz);
        int h, t, o;
        exp_q.delete();
        if (dz) begin
            exp_q.push_back(8'h45);
            exp_q.push_back(8'h52);
            exp_q.push_back(8'h52);
        end else begin
            if (n && r != 0) exp_q.push_back(8'h2D);
            h = r / 100;
            t = (r / 10) % 10;
            o = r % 10;
            if (h != 0) exp_q.push_back(8'(8'h30 + h));
            if (h != 0 || t != 0) exp_q.push_back(8'(8'h30 + t));
            exp_q.push_back(8'(8'h30 + o));
        end
`ifdef CALC_FMT_NEWLINE_EN
        exp_q.push_back(8'h0A);
`endif
    endfunction

    // Called at a negedge; returns at a negedge with the record fully drained.
    task automatic run_record(input int r, input bit n, input bit dz, input bit rnd_ready);
        int  cyc;
        int  idx;
        int  first;
        bit  seen;
        bit  stalled;
        logic [7:0] held_char;
        logic       held_last;
        logic [7:0] got_char;
        logic       got_last;

        for (int w = 0; w < 50 && !in_ready; w++) @(negedge clk);
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        build_exp(r, n, dz);
        first = dz ? 1 : DATA_W + 1;
        in_valid = 1'b1;
        result   = DATA_W'(r);
        neg      = n;
        div_zero = dz;
        @(negedge clk);
        in_valid = 1'b0;
        result   = DATA_W'($urandom);
        neg      = $urandom_range(0, 1) != 0;
        div_zero = $urandom_range(0, 1) != 0;
        cyc = 1;
        idx = 0;
        seen = 1'b0;
        stalled = 1'b0;
        held_char = '0;
        held_last = 1'b0;
        while (idx < exp_q.size() && cyc < 300) begin
            out_ready = rnd_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
            if (out_valid && !seen) begin
                seen = 1'b1;
                check("first_valid_cycle", cyc, first);
            end
            if (stalled) begin
                check("stall_valid_held", {31'b0, out_valid}, 32'd1);
                check("stall_char_held", {24'b0, out_char}, {24'b0, held_char});
                check("stall_last_held", {31'b0, out_last}, {31'b0, held_last});
            end
            if (out_valid) begin
                check("in_ready_busy", {31'b0, in_ready}, 32'd0);
                got_char = out_char;
                got_last = out_last;
                if (out_ready) begin
                    check("char", {24'b0, got_char}, {24'b0, exp_q[idx]});
                    check("last", {31'b0, got_last}, {31'b0, idx == exp_q.size() - 1});
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_char = got_char;
                    held_last = got_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("record_complete", idx, exp_q.size());
        check("in_ready_after_last", {31'b0, in_ready}, 32'd1);
        check("out_valid_after_last", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_char", {24'b0, out_char}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_record(200, 1'b0, 1'b0, 1'b0);
        run_record(7,   1'b1, 1'b0, 1'b0);
        run_record(0,   1'b1, 1'b0, 1'b0);
        run_record(8,   1'b1, 1'b1, 1'b0);
        run_record(45,  1'b0, 1'b0, 1'b1);
        run_record(15,  1'b0, 1'b0, 1'b0);
        run_record(0,   1'b0, 1'b0, 1'b1);
        run_record(255, 1'b1, 1'b0, 1'b1);
        run_record(100, 1'b0, 1'b0, 1'b0);
        run_record(10,  1'b1, 1'b0, 1'b1);
        run_record(99,  1'b0, 1'b0, 1'b0);

        // Reset while the first character of 200 is stalled.
        in_valid = 1'b1;
        result   = DATA_W'(200);
        neg      = 1'b0;
        div_zero = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int w = 0; w < 50 && !out_valid; w++) @(negedge clk);
        check("rst_mid_stalled_valid", {31'b0, out_valid}, 32'd1);
        check("rst_mid_stalled_char", {24'b0, out_char}, 32'h32);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_no_resume", {31'b0, out_valid}, 32'd0);
        run_record(9, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            run_record($urandom_range(0, 255), $urandom_range(0, 1) != 0,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 1) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
